// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    // Controller states: normal flow, or waiting on a data-memory handshake
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } pipe_state_e;

    localparam int         DEF_MEM_TIMEOUT = 64;
    localparam logic [4:0] ZERO_REG        = 5'd0;

    // A load in EX feeds a register read by the instruction in ID; $0 never conflicts
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_wn,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return ex_mem_read && (ex_wn != ZERO_REG) &&
               ((ex_wn == rs) || (uses_rt && (ex_wn == rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stall_timer.sv
// rtl/pipe_hazard_ctrl_stall_timer.sv - memory wait counter with clear/increment/expire
module stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TMR_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Clear wins over increment so entry/exit of the wait always restarts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller; STALL_PERF_EN adds stall counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_WN,
    input  logic       ex_branch_taken,
    input  logic       mem_MemRead,
    input  logic       mem_MemWrite,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       en_pc,
    output logic       en_ifid,
    output logic       en_idex,
    output logic       en_exmem,
    output logic       en_memwb,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       mem_err
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] perf_mem_stall,
    output logic [31:0] perf_lu_stall
`endif
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        mem_err_q;
    logic        mem_err_d;
    logic        tmr_clr;
    logic        tmr_inc;
    logic        tmr_expire;
    logic        mem_acc;
    logic        mem_stall;
    logic        lu_hit;
    logic        req_raw;

    stall_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_stall_timer (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .expire (tmr_expire)
    );

    // Memory handshake FSM: decides whether this cycle is a memory stall
    always_comb begin
        mem_acc   = mem_MemRead | mem_MemWrite;
        state_d   = state_q;
        mem_err_d = mem_err_q;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        mem_stall = 1'b0;
        req_raw   = 1'b0;
        case (state_q)
            RUN: begin
                req_raw = mem_acc;
                if (mem_acc && !dmem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = MWAIT;
                    tmr_clr   = 1'b1;
                end
            end
            MWAIT: begin
                if (dmem_ready) begin
                    req_raw = 1'b1;
                    state_d = RUN;
                    tmr_clr = 1'b1;
                end else if (tmr_expire) begin
                    // Abandon the access: pipeline moves on as if it completed
                    mem_err_d = 1'b1;
                    state_d   = RUN;
                    tmr_clr   = 1'b1;
                end else begin
                    req_raw   = 1'b1;
                    mem_stall = 1'b1;
                    tmr_inc   = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                tmr_clr = 1'b1;
            end
        endcase
    end

    // Enable/flush generation: memory stall > taken branch > load-use > free flow
    always_comb begin
        lu_hit     = load_use_hit(ex_MemRead, ex_WN, id_rs, id_rt, id_uses_rt);
        dmem_req   = req_raw;
        en_pc      = 1'b1;
        en_ifid    = 1'b1;
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (mem_stall) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (ex_branch_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (lu_hit) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end
        // Hold everything quiet while reset is asserted
        if (!rst) begin
            dmem_req   = 1'b0;
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            en_idex    = 1'b0;
            en_exmem   = 1'b0;
            en_memwb   = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
        end
    end

    // State and sticky error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_mem_q;
    logic [31:0] perf_mem_d;
    logic [31:0] perf_lu_q;
    logic [31:0] perf_lu_d;
    logic        lu_bubble;

    // Saturating counts of memory-stall cycles and load-use bubbles
    always_comb begin
        lu_bubble  = !mem_stall && !ex_branch_taken && lu_hit;
        perf_mem_d = perf_mem_q;
        perf_lu_d  = perf_lu_q;
        if (mem_stall && (perf_mem_q != 32'hFFFF_FFFF)) begin
            perf_mem_d = perf_mem_q + 32'd1;
        end
        if (lu_bubble && (perf_lu_q != 32'hFFFF_FFFF)) begin
            perf_lu_d = perf_lu_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_mem_q <= 32'd0;
            perf_lu_q  <= 32'd0;
        end else begin
            perf_mem_q <= perf_mem_d;
            perf_lu_q  <= perf_lu_d;
        end
    end

    assign perf_mem_stall = perf_mem_q;
    assign perf_lu_stall  = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed + randomized self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MT = 8;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_MemRead;
    logic [4:0] ex_WN;
    logic       ex_branch_taken;
    logic       mem_MemRead;
    logic       mem_MemWrite;
    logic       dmem_ready;
    logic       dmem_req;
    logic       en_pc;
    logic       en_ifid;
    logic       en_idex;
    logic       en_exmem;
    logic       en_memwb;
    logic       flush_ifid;
    logic       flush_idex;
    logic       mem_err;
`ifdef STALL_PERF_EN
    logic [31:0] perf_mem_stall;
    logic [31:0] perf_lu_stall;
`endif

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MT),
        .TMR_W       (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_MemRead      (ex_MemRead),
        .ex_WN           (ex_WN),
        .ex_branch_taken (ex_branch_taken),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .en_pc           (en_pc),
        .en_ifid         (en_ifid),
        .en_idex         (en_idex),
        .en_exmem        (en_exmem),
        .en_memwb        (en_memwb),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .mem_err         (mem_err)
`ifdef STALL_PERF_EN
        ,
        .perf_mem_stall  (perf_mem_stall),
        .perf_lu_stall   (perf_lu_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, mem_err}
    function automatic logic [8:0] dut_vec();
        return {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, mem_err};
    endfunction

    task automatic chk(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = dut_vec();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b expected=%b (req,pc,ifid,idex,exmem,memwb,fl_ifid,fl_idex,err) t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding access ages one step per stalled cycle;
    // it is abandoned once it has been stalled MT cycles without a ready.
    int      m_age = 0;
    bit      m_err = 0;
    longint  m_perf_mem = 0;
    longint  m_perf_lu  = 0;

    always @(negedge clk) begin
        logic [8:0] exp;
        bit acc, busy, tmo, stall, lu, req;
        if (!rst) begin
            exp        = 9'b0;
            m_age      = 0;
            m_err      = 0;
            m_perf_mem = 0;
            m_perf_lu  = 0;
        end else begin
            acc   = mem_MemRead || mem_MemWrite;
            busy  = (m_age > 0) || acc;
            tmo   = (m_age == MT) && !dmem_ready;
            stall = busy && !dmem_ready && !tmo;
            req   = (m_age > 0) ? !tmo : acc;
            lu    = ex_MemRead && (ex_WN != 0) &&
                    ((ex_WN == id_rs) || (id_uses_rt && (ex_WN == id_rt)));
            if (stall)                exp = {req, 5'b00000, 2'b00, m_err};
            else if (ex_branch_taken) exp = {req, 5'b11111, 2'b11, m_err};
            else if (lu)              exp = {req, 5'b00111, 2'b01, m_err};
            else                      exp = {req, 5'b11111, 2'b00, m_err};
            m_age = stall ? m_age + 1 : 0;
            if (tmo) m_err = 1;
            if (stall) m_perf_mem++;
            if (!stall && !ex_branch_taken && lu) m_perf_lu++;
        end
        chk("model", exp);
`ifdef STALL_PERF_EN
        total++;
        if ({perf_mem_stall, perf_lu_stall} !== {m_perf_mem[31:0], m_perf_lu[31:0]}) begin
            bad++;
            $display("FAIL perf got=%0d/%0d expected=%0d/%0d t=%0t",
                     perf_mem_stall, perf_lu_stall, m_perf_mem, m_perf_lu, $time);
        end
`endif
    end

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_MemRead = 0; ex_WN = 0;
        ex_branch_taken = 0; mem_MemRead = 0; mem_MemWrite = 0; dmem_ready = 0;
    endtask

    // Inputs are already applied just after a rising edge; check mid-cycle, then move on
    task automatic check_at(input string nm, input logic [8:0] exp);
        @(negedge clk);
        #1;
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int rdy_pct);
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        id_uses_rt      = 1'($urandom_range(0, 1));
        ex_MemRead      = ($urandom_range(0, 99) < 40);
        ex_WN           = 5'($urandom_range(0, 3));
        ex_branch_taken = ($urandom_range(0, 99) < 15);
        mem_MemRead     = ($urandom_range(0, 99) < 25);
        mem_MemWrite    = ($urandom_range(0, 99) < 15);
        dmem_ready      = ($urandom_range(0, 99) < rdy_pct);
    endtask

    initial begin
        int pct_tab[4];
        pct_tab = '{95, 60, 20, 3};
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Outputs stay quiet in reset even with demanding inputs
        mem_MemRead = 1; ex_branch_taken = 1;
        check_at("reset_quiet", 9'b0_00000_00_0);
        rst = 1'b1;
        clear_inputs();

        ex_MemRead = 1; ex_WN = 5; id_rs = 5;
        check_at("load_use", 9'b0_00111_01_0);
        ex_WN = 0; id_rs = 0;
        check_at("zero_reg_no_hazard", 9'b0_11111_00_0);
        ex_WN = 7; id_rt = 7; id_uses_rt = 0;
        check_at("rt_unused_no_hazard", 9'b0_11111_00_0);
        id_uses_rt = 1; ex_branch_taken = 1;
        check_at("branch_over_load_use", 9'b0_11111_11_0);
        clear_inputs();

        mem_MemRead = 1;
        for (int i = 0; i < 3; i++) check_at("mem_wait_stall", 9'b1_00000_00_0);
        dmem_ready = 1;
        check_at("mem_wait_release", 9'b1_11111_00_0);
        mem_MemRead = 0; dmem_ready = 0; mem_MemWrite = 1; dmem_ready = 1;
        check_at("zero_wait_write", 9'b1_11111_00_0);
        clear_inputs();

        mem_MemRead = 1; ex_branch_taken = 1;
        check_at("branch_in_wait_0", 9'b1_00000_00_0);
        check_at("branch_in_wait_1", 9'b1_00000_00_0);
        dmem_ready = 1;
        check_at("branch_on_release", 9'b1_11111_11_0);
        clear_inputs();

        mem_MemRead = 1;
        for (int i = 0; i < MT; i++) check_at("timeout_stall", 9'b1_00000_00_0);
        check_at("timeout_abort", 9'b0_11111_00_0);
        mem_MemRead = 0;
        check_at("err_sticky", 9'b0_11111_00_1);

        mem_MemWrite = 1;
        check_at("wait_before_rst_0", 9'b1_00000_00_1);
        check_at("wait_before_rst_1", 9'b1_00000_00_1);
        rst = 1'b0;
        check_at("rst_mid_wait", 9'b0_00000_00_0);
        rst = 1'b1;
        mem_MemWrite = 0;
        check_at("after_rst", 9'b0_11111_00_0);

        for (int ph = 0; ph < 16; ph++) begin
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 399) != 0);
                rand_inputs(pct_tab[ph % 4]);
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
